risc_sequencer: RTL and testbench

- Fetch/sequencing stage for the 8-bit accumulator RISC core. It sits directly upstream of the controller and produces the controller's `phase` and `opcode` inputs.
- Holds the 3-bit phase counter, instruction register (IR), program counter (PC) and halt state. It consumes the controller strobes `ld_ir`, `inc_pc`, `ld_pc`, `halt` and `sel`, and drives the memory address.
- Also keeps a retired-instruction counter for debug.

---
 rtl/risc_sequencer.sv | 91 +++++++++
 tb/tb_risc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_sequencer.sv
// risc_sequencer: fetch/sequencing stage of the 8-bit accumulator RISC core.
// Owns the instruction phase counter, instruction register, program counter,
// halt flag and a saturating retired-instruction counter. The controller's
// strobes steer these registers; the stage feeds phase/opcode back to it.
module risc_sequencer #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DWIDTH-1:0]          data_in,
    input  logic                       ld_ir,
    input  logic                       inc_pc,
    input  logic                       ld_pc,
    input  logic                       halt,
    input  logic                       sel,
    input  logic                       resume,
    output logic [2:0]                 phase,
    output logic [DWIDTH-AWIDTH-1:0]   opcode,
    output logic [AWIDTH-1:0]          ir_addr,
    output logic [AWIDTH-1:0]          pc_addr,
    output logic [AWIDTH-1:0]          mem_addr,
    output logic                       halted,
    output logic [CWIDTH-1:0]          instr_cnt
);

    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

    logic [DWIDTH-1:0] ir;
    logic [AWIDTH-1:0] pc;

    // Phase counter free-runs 0..7 while the machine runs and freezes when halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 3'd0;
        end else if (!halted) begin
            phase <= phase + 3'd1;
        end
    end

    // Instruction register captures the memory bus only while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (!halted && ld_ir) begin
            ir <= data_in;
        end
    end

    // Program counter: a jump takes the pre-edge operand and beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (!halted) begin
            if (ld_pc) begin
                pc <= ir[AWIDTH-1:0];
            end else if (inc_pc) begin
                pc <= pc + AWIDTH'(1);
            end
        end
    end

    // Halt flag: halt wins over resume while running; resume only clears a halted machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (!halted) begin
            if (halt) begin
                halted <= 1'b1;
            end
        end else if (resume) begin
            halted <= 1'b0;
        end
    end

    // Retired-instruction counter bumps on each running 7->0 wrap and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if (!halted && phase == 3'd7 && instr_cnt != CNT_MAX) begin
            instr_cnt <= instr_cnt + CWIDTH'(1);
        end
    end

    assign opcode   = ir[DWIDTH-1:AWIDTH];
    assign ir_addr  = ir[AWIDTH-1:0];
    assign pc_addr  = pc;
    assign mem_addr = sel ? pc : ir[AWIDTH-1:0];

endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer: scoreboard bench for risc_sequencer. A behavioural model
// predicts the post-edge state for every stimulus step; the prediction is queued
// when the step is driven and compared after the edge. A second instance with a
// 4-bit retired counter exercises counter saturation on the same stimulus.
module tb_risc_sequencer;

    typedef struct {
        logic [2:0]  phase;
        logic [7:0]  ir;
        logic [4:0]  pc;
        logic        halted;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        ld_ir;
    logic        inc_pc;
    logic        ld_pc;
    logic        halt;
    logic        sel;
    logic        resume;

    logic [2:0]  phase;
    logic [2:0]  opcode;
    logic [4:0]  ir_addr;
    logic [4:0]  pc_addr;
    logic [4:0]  mem_addr;
    logic        halted;
    logic [15:0] instr_cnt;

    logic [2:0]  phase4;
    logic [2:0]  opcode4;
    logic [4:0]  ir_addr4;
    logic [4:0]  pc_addr4;
    logic [4:0]  mem_addr4;
    logic        halted4;
    logic [3:0]  instr_cnt4;

    int tests_run = 0;
    int failures  = 0;

    exp_t sb_q[$];

    logic [2:0]  m_phase  = 3'd0;
    logic [7:0]  m_ir     = 8'd0;
    logic [4:0]  m_pc     = 5'd0;
    logic        m_halted = 1'b0;
    logic [15:0] m_cnt    = 16'd0;
    logic [3:0]  m_cnt4   = 4'd0;

    risc_sequencer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .halt(halt), .sel(sel), .resume(resume),
        .phase(phase), .opcode(opcode), .ir_addr(ir_addr), .pc_addr(pc_addr),
        .mem_addr(mem_addr), .halted(halted), .instr_cnt(instr_cnt)
    );

    risc_sequencer #(.CWIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .halt(halt), .sel(sel), .resume(resume),
        .phase(phase4), .opcode(opcode4), .ir_addr(ir_addr4), .pc_addr(pc_addr4),
        .mem_addr(mem_addr4), .halted(halted4), .instr_cnt(instr_cnt4)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, predict the next state, queue it, clock, then compare.
    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic lir,
                                 input logic inc, input logic lpc, input logic h,
                                 input logic s, input logic res);
        exp_t e;
        exp_t got;
        rst = r; data_in = d; ld_ir = lir; inc_pc = inc; ld_pc = lpc;
        halt = h; sel = s; resume = res;
        if (r) begin
            m_phase = 3'd0; m_ir = 8'd0; m_pc = 5'd0; m_halted = 1'b0;
            m_cnt = 16'd0; m_cnt4 = 4'd0;
        end else if (!m_halted) begin
            if (m_phase == 3'd7) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
            end
            m_phase = m_phase + 3'd1;
            if (lpc) m_pc = m_ir[4:0];
            else if (inc) m_pc = m_pc + 5'd1;
            if (lir) m_ir = d;
            if (h) m_halted = 1'b1;
        end else if (res) begin
            m_halted = 1'b0;
        end
        e.phase = m_phase; e.ir = m_ir; e.pc = m_pc; e.halted = m_halted;
        e.cnt = m_cnt; e.cnt4 = m_cnt4;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checkOutput("phase", 32'(phase), 32'(got.phase));
        checkOutput("opcode", 32'(opcode), 32'(got.ir[7:5]));
        checkOutput("ir_addr", 32'(ir_addr), 32'(got.ir[4:0]));
        checkOutput("pc_addr", 32'(pc_addr), 32'(got.pc));
        checkOutput("mem_addr", 32'(mem_addr), 32'(sel ? got.pc : got.ir[4:0]));
        checkOutput("halted", 32'(halted), 32'(got.halted));
        checkOutput("instr_cnt", 32'(instr_cnt), 32'(got.cnt));
        checkOutput("instr_cnt4", 32'(instr_cnt4), 32'(got.cnt4));
        checkOutput("dut4_state",
                    {10'd0, phase4, opcode4, ir_addr4, pc_addr4, halted4, mem_addr4},
                    {10'd0, got.phase, got.ir[7:5], got.ir[4:0], got.pc, got.halted,
                     (sel ? got.pc : got.ir[4:0])});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic runToPhase(input logic [2:0] p);
        for (int i = 0; i < 8 && m_phase != p; i++) idle(1);
    endtask

    logic [15:0] saved_cnt;

    initial begin
        rst = 1'b1; data_in = 8'h00; ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0;
        halt = 1'b0; sel = 1'b1; resume = 1'b0;

        // Reset state
        applyStimulus(1, 8'h00, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 8'h00, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_pc", 32'(pc_addr), 32'd0);
        checkOutput("rst_ir", {24'd0, opcode, ir_addr}, 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_cnt", 32'(instr_cnt), 32'd0);

        // 16 idle cycles: two full phase rotations
        idle(16);
        checkOutput("idle_phase", 32'(phase), 32'd0);
        checkOutput("idle_pc", 32'(pc_addr), 32'd0);
        checkOutput("idle_cnt", 32'(instr_cnt), 32'd2);
        checkOutput("idle_halted", 32'(halted), 32'd0);

        // Fetch A7 on the phase-2 edge, increment on the phase-4 edge
        idle(2);
        applyStimulus(0, 8'hA7, 1, 0, 0, 0, 1, 0);
        idle(1);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        checkOutput("fetch_opcode", 32'(opcode), 32'd5);
        checkOutput("fetch_ir_addr", 32'(ir_addr), 32'd7);
        checkOutput("fetch_pc", 32'(pc_addr), 32'd1);
        sel = 1'b1; #1;
        checkOutput("mux_sel1", 32'(mem_addr), 32'd1);
        sel = 1'b0; #1;
        checkOutput("mux_sel0", 32'(mem_addr), 32'd7);
        sel = 1'b1;

        // JMP 28 from pc=3, then increment through the wrap
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        checkOutput("pre_jmp_pc", 32'(pc_addr), 32'd3);
        applyStimulus(0, 8'hFC, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0, 1, 0);
        checkOutput("jmp_pc", 32'(pc_addr), 32'd28);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        checkOutput("inc_pc29", 32'(pc_addr), 32'd29);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        checkOutput("inc_pc30", 32'(pc_addr), 32'd30);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        checkOutput("inc_pc31", 32'(pc_addr), 32'd31);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 1, 0);
        checkOutput("inc_pc_wrap", 32'(pc_addr), 32'd0);

        // ld_pc uses the old operand when ld_ir fires on the same edge
        applyStimulus(0, 8'hE9, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 8'hE3, 1, 0, 1, 0, 1, 0);
        checkOutput("ldpc_old_operand", 32'(pc_addr), 32'd9);
        checkOutput("ldpc_new_ir_addr", 32'(ir_addr), 32'd3);

        // Halt at phase 4 with pc=6 and inc_pc on the same edge
        applyStimulus(0, 8'h06, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0, 1, 0);
        runToPhase(3'd4);
        applyStimulus(0, 8'h00, 0, 1, 0, 1, 1, 0);
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_phase", 32'(phase), 32'd5);
        checkOutput("halt_pc", 32'(pc_addr), 32'd7);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 8'($urandom), i[0], ~i[0], i[1], i[2], 1, 0);
        end
        checkOutput("frozen_phase", 32'(phase), 32'd5);
        checkOutput("frozen_pc", 32'(pc_addr), 32'd7);
        checkOutput("frozen_ir", {24'd0, opcode, ir_addr}, 32'h06);
        saved_cnt = instr_cnt;
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 1);
        checkOutput("resume_halted", 32'(halted), 32'd0);
        checkOutput("resume_phase", 32'(phase), 32'd5);
        idle(3);
        checkOutput("resume_phase_wrap", 32'(phase), 32'd0);
        checkOutput("resume_cnt", 32'(instr_cnt), 32'(saved_cnt + 16'd1));

        // halt and resume together while running: halt wins
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 1, 1);
        checkOutput("halt_beats_resume", 32'(halted), 32'd1);
        // reset dominates resume while halted
        applyStimulus(1, 8'h00, 0, 0, 0, 0, 1, 1);
        checkOutput("rst_halted_clear", 32'(halted), 32'd0);
        checkOutput("rst_phase2", 32'(phase), 32'd0);
        checkOutput("rst_pc2", 32'(pc_addr), 32'd0);
        checkOutput("rst_cnt2", 32'(instr_cnt), 32'd0);

        // 17 instructions: narrow counter saturates at 15
        idle(17 * 8);
        checkOutput("sat_cnt4", 32'(instr_cnt4), 32'd15);
        checkOutput("sat_cnt16", 32'(instr_cnt), 32'd17);

        // Random strobes against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 60) == 0), 8'($urandom), 1'($urandom),
                          1'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 15) == 0), 1'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
